// File: rtl/conv_stream_feeder.sv
// Host-side loader for the convolution accelerator: streams kernel and feature beats
// from linear memory over a valid/ready bus, pads the last group, and checks output order.
module conv_stream_feeder #(
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 32,
  parameter int DATA_WIDTH         = 16,
  parameter int BUS_WORDS          = 3,
  parameter int KERNEL_BEATS       = 144,
  parameter int FEAT_BEATS         = 6,
  parameter int MEM_AW             = 17
) (
  input  logic                                  clk,
  input  logic                                  rst_in,
  input  logic                                  go,
  input  logic [1:0]                            stride_mode,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  seq_error,
  output logic [MEM_AW-1:0]                     out_count,
  output logic                                  mem_re,
  output logic [MEM_AW-1:0]                     mem_addr,
  input  logic [BUS_WORDS*DATA_WIDTH-1:0]       mem_rdata,
  output logic                                  acc_start,
  input  logic                                  acc_running,
  output logic                                  bus_valid,
  input  logic                                  bus_ready,
  output logic [BUS_WORDS*DATA_WIDTH-1:0]       bus_data,
  input  logic                                  output_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch
);

  localparam int BDW = BUS_WORDS * DATA_WIDTH;
  localparam logic [MEM_AW-1:0] ONE     = MEM_AW'(1);
  localparam logic [MEM_AW-1:0] KB_LAST = MEM_AW'(KERNEL_BEATS - 1);
  localparam logic [MEM_AW-1:0] KB_W    = MEM_AW'(KERNEL_BEATS);
  localparam logic [MEM_AW-1:0] FB_W    = MEM_AW'(FEAT_BEATS);
  localparam logic [MEM_AW-1:0] FB_LAST = MEM_AW'(FEAT_BEATS - 1);
  localparam logic [MEM_AW-1:0] W_W     = MEM_AW'(FEATURE_MAP_WIDTH);
  localparam logic [MEM_AW-1:0] H_W     = MEM_AW'(FEATURE_MAP_HEIGHT);
  localparam logic [MEM_AW-1:0] BW_W    = MEM_AW'(BUS_WORDS);

  // state   | meaning
  // IDLE    | waiting for a legal go
  // START   | acc_start pulse, first memory read issued
  // KERNEL  | streaming kernel beats
  // FEATURE | streaming feature beats
  // PAD     | sending FEAT_BEATS zero beats
  // DRAIN   | waiting for all outputs and accelerator idle
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_KERNEL, S_FEATURE, S_PAD, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   stride_q, stride_d;
  logic [MEM_AW-1:0]   total_out_q, total_out_d;
  logic [MEM_AW-1:0]   total_mem_q, total_mem_d;
  logic [MEM_AW-1:0]   rd_addr_q, rd_addr_d;
  logic [MEM_AW-1:0]   beat_idx_q, beat_idx_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [BDW-1:0]      buf_q [0:1];
  logic [BDW-1:0]      buf_d [0:1];
  logic [MEM_AW-1:0]   ex_q, ex_d;
  logic [MEM_AW-1:0]   ey_q, ey_d;
  logic [MEM_AW-1:0]   k_q, k_d;
  logic [MEM_AW-1:0]   ech_q, ech_d;
  logic [MEM_AW-1:0]   out_count_q, out_count_d;
  logic                seq_error_q, seq_error_d;

  logic                go_ok;
  logic                streaming;
  logic                xfer;
  logic                xfer_stream;
  logic [1:0]          cnt_after;
  logic [BDW-1:0]      head_data;
  logic [MEM_AW-1:0]   n_pos;
  logic [MEM_AW-1:0]   n_out;

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign seq_error = seq_error_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    total_out_d = total_out_q;
    total_mem_d = total_mem_q;
    rd_addr_d   = rd_addr_q;
    beat_idx_d  = beat_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_d       = buf_q;
    ex_d        = ex_q;
    ey_d        = ey_q;
    k_d         = k_q;
    ech_d       = ech_q;
    out_count_d = out_count_q;
    seq_error_d = seq_error_q;
    acc_start   = 1'b0;
    done        = 1'b0;

    go_ok = (state_q == S_IDLE) && go && (stride_mode != 2'd3);
    n_pos = (W_W >> stride_mode) * (H_W >> stride_mode);
    n_out = FB_W * n_pos;

    // The skid buffer is bypassed when empty so a beat is presented the cycle it returns.
    streaming   = (state_q == S_KERNEL) || (state_q == S_FEATURE);
    head_data   = (cnt_q != 2'd0) ? buf_q[rd_ptr_q] : mem_rdata;
    bus_valid   = (streaming && ((cnt_q != 2'd0) || pend_q)) || (state_q == S_PAD);
    bus_data    = (streaming && bus_valid) ? head_data : '0;
    xfer        = bus_valid && bus_ready;
    xfer_stream = xfer && streaming;
    cnt_after   = cnt_q + {1'b0, pend_q} - {1'b0, xfer_stream};

    mem_re   = ((state_q == S_START) || streaming) && (rd_addr_q < total_mem_q)
               && (cnt_after <= 2'd1);
    mem_addr = mem_re ? rd_addr_q : '0;
    cnt_d    = cnt_after;
    pend_d   = mem_re;
    if (mem_re) rd_addr_d = rd_addr_q + ONE;
    if (pend_q && !(xfer_stream && (cnt_q == 2'd0))) begin
      buf_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (xfer_stream && (cnt_q != 2'd0)) rd_ptr_d = !rd_ptr_q;

    case (state_q)
      S_START: begin
        acc_start = 1'b1;
        state_d   = S_KERNEL;
      end
      S_KERNEL: if (xfer) begin
        beat_idx_d = beat_idx_q + ONE;
        if (beat_idx_q == KB_LAST) state_d = S_FEATURE;
      end
      S_FEATURE: if (xfer) begin
        beat_idx_d = beat_idx_q + ONE;
        if (beat_idx_q == total_mem_q - ONE) begin
          state_d    = S_PAD;
          beat_idx_d = '0;
        end
      end
      S_PAD: if (xfer) begin
        beat_idx_d = beat_idx_q + ONE;
        if (beat_idx_q == FB_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: if ((out_count_q == total_out_q) && !acc_running) state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Expected output raster: x outer, y inner, FEAT_BEATS channel groups per position.
    if (output_valid) begin
      out_count_d = out_count_q + ONE;
      if ((state_q == S_IDLE) || (state_q == S_DONE) || (out_count_q >= total_out_q)) begin
        seq_error_d = 1'b1;
      end else begin
        if ((MEM_AW'(output_x) != ex_q) || (MEM_AW'(output_y) != ey_q)
            || (MEM_AW'(output_ch) != ech_q))
          seq_error_d = 1'b1;
        if (k_q == FB_LAST) begin
          k_d   = '0;
          ech_d = '0;
          if (ey_q >= H_W - stride_q) begin
            ey_d = '0;
            ex_d = ex_q + stride_q;
          end else begin
            ey_d = ey_q + stride_q;
          end
        end else begin
          k_d   = k_q + ONE;
          ech_d = ech_q + BW_W;
        end
      end
    end

    if (go_ok) begin
      state_d     = S_START;
      stride_d    = ONE << stride_mode;
      total_out_d = n_out;
      total_mem_d = KB_W + n_out;
      rd_addr_d   = '0;
      beat_idx_d  = '0;
      cnt_d       = '0;
      pend_d      = 1'b0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      ex_d        = '0;
      ey_d        = '0;
      k_d         = '0;
      ech_d       = '0;
      out_count_d = '0;
      seq_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      stride_q    <= '0;
      total_out_q <= '0;
      total_mem_q <= '0;
      rd_addr_q   <= '0;
      beat_idx_q  <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      ex_q        <= '0;
      ey_q        <= '0;
      k_q         <= '0;
      ech_q       <= '0;
      out_count_q <= '0;
      seq_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      total_out_q <= total_out_d;
      total_mem_q <= total_mem_d;
      rd_addr_q   <= rd_addr_d;
      beat_idx_q  <= beat_idx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_q       <= buf_d;
      ex_q        <= ex_d;
      ey_q        <= ey_d;
      k_q         <= k_d;
      ech_q       <= ech_d;
      out_count_q <= out_count_d;
      seq_error_q <= seq_error_d;
    end
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder on a 4x4 map: memory and accelerator models,
// beat-by-beat stream checks, output-order checking and reset/ignored-go cases.
module tb_conv_stream_feeder;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int OC  = 32;
  localparam int DW  = 16;
  localparam int BWD = 3;
  localparam int KB  = 144;
  localparam int FB  = 6;
  localparam int AW  = 17;
  localparam int BDW = BWD * DW;

  logic            clk = 1'b0;
  logic            rst_in = 1'b1;
  logic            go = 1'b0;
  logic [1:0]      stride_mode = 2'd0;
  logic            busy, done, seq_error;
  logic [AW-1:0]   out_count;
  logic            mem_re;
  logic [AW-1:0]   mem_addr;
  logic [BDW-1:0]  mem_rdata = '0;
  logic            acc_start;
  logic            acc_running = 1'b0;
  logic            bus_valid;
  logic            bus_ready = 1'b1;
  logic [BDW-1:0]  bus_data;
  logic            output_valid = 1'b0;
  logic [1:0]      output_x = '0;
  logic [1:0]      output_y = '0;
  logic [4:0]      output_ch = '0;

  int n_checks = 0;
  int n_pass   = 0;

  conv_stream_feeder #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(OC),
    .DATA_WIDTH(DW), .BUS_WORDS(BWD), .KERNEL_BEATS(KB), .FEAT_BEATS(FB), .MEM_AW(AW)
  ) dut (
    .clk(clk), .rst_in(rst_in), .go(go), .stride_mode(stride_mode),
    .busy(busy), .done(done), .seq_error(seq_error), .out_count(out_count),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .acc_start(acc_start), .acc_running(acc_running),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch)
  );

  always #5 clk = ~clk;

  function automatic logic [BDW-1:0] beat_of(input int a);
    return {DW'(3 * a + 2), DW'(3 * a + 1), DW'(3 * a)};
  endfunction

  always @(posedge clk) mem_rdata <= mem_re ? beat_of(int'(mem_addr)) : '1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_seq_err"}, 64'(seq_error), 64'd0);
    chk({tag, "_out_count"}, 64'(out_count), 64'd0);
    chk({tag, "_mem_re"}, 64'(mem_re), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_acc_start"}, 64'(acc_start), 64'd0);
    chk({tag, "_bus_valid"}, 64'(bus_valid), 64'd0);
    chk({tag, "_bus_data"}, 64'(bus_data), 64'd0);
  endtask

  // One run: go at cycle 0, accelerator model emits outputs once the kernel is streamed.
  task automatic do_run(input logic [1:0] sm, input bit rnd, input bit inject,
                        input bit busy_go, input int abort_at);
    int s, n, m, nout, beats, outs, first_valid, start_cnt, re_cnt, inj_cyc, cyc;
    bit done_seen, prev_stall;
    logic [BDW-1:0] prev_data;
    int ox[$], oy[$], oc[$];
    s = 1 << sm;
    n = (W / s) * (H / s);
    m = KB + FB * n;
    nout = FB * n;
    for (int x = 0; x < W; x += s)
      for (int y = 0; y < H; y += s)
        for (int k = 0; k < FB; k++) begin
          ox.push_back(x); oy.push_back(y); oc.push_back(3 * k);
        end
    beats = 0; outs = 0; first_valid = -1; start_cnt = 0; re_cnt = 0; inj_cyc = -10;
    done_seen = 0; prev_stall = 0; prev_data = '0;
    @(negedge clk);
    for (cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      go          = (cyc == 0) || (busy_go && cyc == 10);
      stride_mode = (cyc == 0) ? sm : 2'd0;
      bus_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      output_valid = 1'b0;
      if (beats >= KB && outs < nout) begin
        output_valid = 1'b1;
        output_x  = 2'(ox[outs]);
        output_y  = 2'(oy[outs]);
        output_ch = 5'(oc[outs]);
        if (inject && outs == 1) begin
          output_ch = 5'd4;
          inj_cyc   = cyc;
        end
        outs++;
      end else if (outs == nout && nout > 0) begin
        acc_running = 1'b0;
      end
      #1;
      if (cyc == 1) begin
        chk("acc_start_cycle1", 64'(acc_start), 64'd1);
        chk("busy_cycle1", 64'(busy), 64'd1);
        chk("seq_err_cleared_by_go", 64'(seq_error), 64'd0);
      end
      if (acc_start) begin
        start_cnt++;
        acc_running = 1'b1;
      end
      if (mem_re) re_cnt++;
      if (prev_stall) begin
        chk("stall_valid_held", 64'(bus_valid), 64'd1);
        chk("stall_data_held", 64'(bus_data), 64'(prev_data));
      end
      if (bus_valid && first_valid < 0) first_valid = cyc;
      if (bus_valid && bus_ready) begin
        chk($sformatf("beat%0d", beats), 64'(bus_data),
            (beats < m) ? 64'(beat_of(beats)) : 64'd0);
        beats++;
      end
      prev_stall = bus_valid && !bus_ready;
      prev_data  = bus_data;
      if (inject && cyc == inj_cyc) chk("seq_err_before_bad", 64'(seq_error), 64'd0);
      if (inject && cyc == inj_cyc + 1) chk("seq_err_after_bad", 64'(seq_error), 64'd1);
      if (done) begin
        done_seen = 1;
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      if (abort_at >= 0 && beats == abort_at) break;
      @(negedge clk);
    end
    go = 1'b0;
    output_valid = 1'b0;
    if (abort_at >= 0) return;
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("beat_total", 64'(beats), 64'(m + FB));
    chk("mem_read_total", 64'(re_cnt), 64'(m));
    chk("acc_start_pulses", 64'(start_cnt), 64'd1);
    chk("first_valid_cycle", 64'(first_valid), 64'd2);
    chk("out_count_final", 64'(out_count), 64'(nout));
    chk("seq_err_final", 64'(seq_error), 64'(inject));
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_in = 1'b0;

    do_run(2'd0, 1'b0, 1'b0, 1'b0, -1);
    do_run(2'd0, 1'b1, 1'b0, 1'b0, -1);
    do_run(2'd1, 1'b0, 1'b0, 1'b1, -1);
    do_run(2'd1, 1'b0, 1'b1, 1'b0, -1);

    do_run(2'd0, 1'b0, 1'b0, 1'b0, 50);
    rst_in = 1'b1;
    acc_running = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("abort");
    rst_in = 1'b0;
    do_run(2'd2, 1'b0, 1'b0, 1'b0, -1);

    @(negedge clk);
    go = 1'b1;
    stride_mode = 2'd3;
    @(negedge clk);
    go = 1'b0;
    stride_mode = 2'd0;
    #1;
    chk("illegal_go_acc_start", 64'(acc_start), 64'd0);
    chk("illegal_go_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    chk("illegal_go_acc_start2", 64'(acc_start), 64'd0);
    chk("illegal_go_mem_re", 64'(mem_re), 64'd0);
    @(negedge clk);
    output_valid = 1'b1;
    output_x = '0; output_y = '0; output_ch = '0;
    @(negedge clk);
    output_valid = 1'b0;
    #1;
    chk("idle_output_seq_err", 64'(seq_error), 64'd1);
    do_run(2'd1, 1'b0, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
